// File: rtl/regfile_cmd_ctrl.sv
// Byte-command master: parses framed write/read commands from the UART receive
// path, drives the register-file port and returns read data to the transmitter.
module regfile_cmd_ctrl #(
  parameter int          ADDR    = 4,
  parameter logic [7:0]  WR_CMD  = 8'hAA,
  parameter logic [7:0]  RD_CMD  = 8'hBB,
  parameter int          TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rf_wr_en,
  output logic            rf_rd_en,
  output logic [ADDR-1:0] rf_addr,
  output logic [7:0]      rf_wr_data,
  input  logic [7:0]      rf_rd_data,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_busy,
  output logic            cmd_err,
  output logic [2:0]      state_o
);

  // Handshakes: rx_valid is a one-cycle strobe with no backpressure, so a byte
  // is consumed (or rejected with cmd_err) in the cycle it appears. tx_valid is
  // only raised while tx_busy is low; the transfer completes in that cycle.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_ADDR  = 3'd1,
    S_W_DATA  = 3'd2,
    S_R_ADDR  = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_TX_SEND = 3'd6
  } state_e;

  localparam logic [31:0] MAX_ADDR   = 32'((64'd1 << ADDR) - 64'd1);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic            err_q, err_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      txd_q, txd_d;
  logic            addr_ok;

  assign addr_ok = ({24'd0, rx_data} <= MAX_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = 16'd0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == WR_CMD)      state_d = S_W_ADDR;
          else if (rx_data == RD_CMD) state_d = S_R_ADDR;
          else                        err_d   = 1'b1;
        end
      end
      S_W_ADDR, S_W_DATA, S_R_ADDR: begin
        if (rx_valid) begin
          if (state_q == S_W_DATA) begin
            wdata_d = rx_data;
            wr_en_d = 1'b1;
            state_d = S_IDLE;
          end else if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d = rx_data[ADDR-1:0];
            if (state_q == S_W_ADDR) begin
              state_d = S_W_DATA;
            end else begin
              rd_en_d = 1'b1;
              state_d = S_RD_REQ;
            end
          end
        end else if (cnt_q == TIMEOUT_M1) begin
          // Inter-byte gap exhausted: abandon the frame without touching the port.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD_REQ: begin
        err_d   = rx_valid;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        err_d   = rx_valid;
        txd_d   = rf_rd_data;
        state_d = S_TX_SEND;
      end
      S_TX_SEND: begin
        err_d = rx_valid;
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      txd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_rd_en   = rd_en_q;
  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign tx_data    = txd_q;
  assign cmd_err    = err_q;
  assign tx_valid   = (state_q == S_TX_SEND) && !tx_busy;
  assign state_o    = state_q;

endmodule
